// File: rtl/screen_ram_arbiter.sv
// screen_ram_arbiter: owns the single framebuffer RAM port. VGA whole-word
// reads have strict priority; CPU pixel writes are queued in a FIFO and
// applied as read-modify-write nibble updates.
// Optional build macro SCREEN_ARB_COALESCE_EN: merges a second queued write
// to the same word into one RMW.
module screen_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PIX_ADDR_WIDTH = 19,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vga_req,
    input  logic [ADDR_WIDTH-1:0]     vga_addr,
    output logic [DATA_WIDTH-1:0]     vga_data,
    output logic                      vga_valid,
    output logic                      vga_overrun,
    input  logic                      cpu_wr,
    input  logic [PIX_ADDR_WIDTH-1:0] cpu_pix_addr,
    input  logic [3:0]                cpu_color,
    output logic                      cpu_ready,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_din,
    output logic                      ram_we,
    input  logic [DATA_WIDTH-1:0]     ram_dout
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] word;
        logic [2:0]            nib;
        logic [3:0]            color;
    } wr_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_VGA = 2'd1,
        RD_CPU = 2'd2,
        WR_CPU = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0] vga_data_q, vga_data_d;
    logic                  vga_valid_q, vga_valid_d;
    logic [DATA_WIDTH-1:0] rmw_q, rmw_d;
    logic                  coal_q, coal_d;

    wr_entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ready_q, ready_d;

    wr_entry_t             head;
    wr_entry_t             push_entry;
    logic                  push;
    logic                  fifo_empty;
    logic                  pend_consume;
    logic [1:0]            pop_cnt;

    // Replace one 4-bit pixel inside a packed word
    function automatic logic [DATA_WIDTH-1:0] put_nib(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [2:0]            nib,
                                                      input logic [3:0]            color);
        logic [DATA_WIDTH-1:0] r;
        r = w;
        r[{nib, 2'b00} +: 4] = color;
        return r;
    endfunction

    assign head       = fifo_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign push       = cpu_wr & ready_q;
    assign push_entry = {cpu_pix_addr[3 +: ADDR_WIDTH], cpu_pix_addr[2:0], cpu_color};

`ifdef SCREEN_ARB_COALESCE_EN
    wr_entry_t second;
    assign second = fifo_q[rd_ptr_q + PTR_W'(1)];
`endif

    assign vga_data    = vga_data_q;
    assign vga_valid   = vga_valid_q;
    assign vga_overrun = overrun_q;
    assign cpu_ready   = ready_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: VGA wins any tie with a queued CPU write
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = RD_VGA;
                end else if (!fifo_empty) begin
                    state_d = RD_CPU;
                end
            end
            RD_VGA:  state_d = IDLE;
            RD_CPU:  state_d = WR_CPU;
            WR_CPU:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State outputs: RAM port drive, read capture and RMW merge
    always_comb begin
        ram_addr     = '0;
        ram_din      = '0;
        ram_we       = 1'b0;
        pop_cnt      = 2'd0;
        pend_consume = 1'b0;
        vga_data_d   = vga_data_q;
        vga_valid_d  = 1'b0;
        rmw_d        = rmw_q;
        coal_d       = coal_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    ram_addr = addr_q;
                end else if (!fifo_empty) begin
                    ram_addr = head.word;
                end
            end
            RD_VGA: begin
                vga_data_d   = ram_dout;
                vga_valid_d  = 1'b1;
                pend_consume = 1'b1;
            end
            RD_CPU: begin
                rmw_d  = put_nib(ram_dout, head.nib, head.color);
                coal_d = 1'b0;
`ifdef SCREEN_ARB_COALESCE_EN
                if ((count_q >= CNT_W'(2)) && (second.word == head.word)) begin
                    rmw_d  = put_nib(put_nib(ram_dout, head.nib, head.color),
                                     second.nib, second.color);
                    coal_d = 1'b1;
                end
`endif
            end
            WR_CPU: begin
                ram_we   = 1'b1;
                ram_addr = head.word;
                ram_din  = rmw_q;
                pop_cnt  = coal_q ? 2'd2 : 2'd1;
            end
            default: ;
        endcase
    end

    // VGA request capture: newest request wins, overwrite of an unserved one is sticky
    always_comb begin
        pend_d    = pend_q;
        addr_d    = addr_q;
        overrun_d = overrun_q;
        if (pend_consume) begin
            pend_d = 1'b0;
        end
        if (vga_req) begin
            pend_d = 1'b1;
            addr_d = vga_addr;
            if (pend_q && !pend_consume) begin
                overrun_d = 1'b1;
            end
        end
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop_cnt);
        ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
    end

    // Datapath and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q      <= 1'b0;
            addr_q      <= '0;
            overrun_q   <= 1'b0;
            vga_data_q  <= '0;
            vga_valid_q <= 1'b0;
            rmw_q       <= '0;
            coal_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ready_q     <= 1'b1;
        end else begin
            pend_q      <= pend_d;
            addr_q      <= addr_d;
            overrun_q   <= overrun_d;
            vga_data_q  <= vga_data_d;
            vga_valid_q <= vga_valid_d;
            rmw_q       <= rmw_d;
            coal_q      <= coal_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ready_q     <= ready_d;
        end
    end

    // FIFO storage; contents are don't-care until counted in
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Scoreboard bench for screen_ram_arbiter: directed cases plus randomized
// traffic against a pixel-level memory model.
module tb_screen_ram_arbiter;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 32;
    localparam int unsigned PW    = 19;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vga_data;
    logic          vga_valid;
    logic          vga_overrun;
    logic          cpu_wr;
    logic [PW-1:0] cpu_pix_addr;
    logic [3:0]    cpu_color;
    logic          cpu_ready;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    screen_ram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_ADDR_WIDTH(PW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
        .vga_valid(vga_valid), .vga_overrun(vga_overrun),
        .cpu_wr(cpu_wr), .cpu_pix_addr(cpu_pix_addr), .cpu_color(cpu_color),
        .cpu_ready(cpu_ready),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    // Synchronous single-port RAM, read-before-write
    logic [31:0] ram     [0:65535];
    logic [31:0] ref_img [0:65535];

    always @(posedge clk) begin
        ram_dout <= ram[ram_addr];
        if (ram_we) ram[ram_addr] = ram_din;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int word; int nib; logic [3:0] color; int pcyc; } wr_t;
    typedef struct { logic [31:0] data; int rcyc; int lmin; int lmax; } vexp_t;

    wr_t   wq[$];
    vexp_t vq[$];
    int    checks = 0;
    int    errors = 0;
    int    mcount = 0;
    int    wr_count = 0;
    int    drop_count = 0;
    int    last_wr_cyc = 0;
    int    last_valid_cyc = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_din = '0;

    function automatic logic [31:0] init_val(input int a);
        logic [15:0] lo;
        lo = a[15:0];
        return {lo ^ 16'hA5C3, ~lo};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    // Monitor: FIFO occupancy model, write scoreboard, VGA read scoreboard
    always @(negedge clk) begin
        bit          accept;
        int          n;
        wr_t         e;
        wr_t         e2;
        vexp_t       v;
        logic [31:0] exp;
        if (!rst) begin
            wq.delete();
            vq.delete();
            mcount = 0;
        end else begin
            accept = cpu_wr && (mcount != DEPTH);
            chk("cpu_ready", 32'(cpu_ready), 32'(mcount != DEPTH));
            if (cpu_wr && !accept) drop_count++;
            if (ram_we) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0h din %0h, required no write", ram_addr, ram_din);
                end else begin
                    e = wq.pop_front();
                    exp = ref_img[e.word];
                    exp[e.nib*4 +: 4] = e.color;
                    n = 1;
`ifdef SCREEN_ARB_COALESCE_EN
                    if (wq.size() > 0 && wq[0].word == e.word && wq[0].pcyc + 2 <= cyc) begin
                        e2 = wq.pop_front();
                        exp[e2.nib*4 +: 4] = e2.color;
                        n = 2;
                    end
`endif
                    chk("wr_addr", 32'(ram_addr), 32'(e.word));
                    chk("wr_din", ram_din, exp);
                    ref_img[e.word] = exp;
                    mcount -= n;
                    wr_count++;
                    last_wr_cyc = cyc;
                    last_addr = 32'(ram_addr);
                    last_din = ram_din;
                end
            end
            if (accept) begin
                e.word = int'(cpu_pix_addr >> 3);
                e.nib = int'(cpu_pix_addr[2:0]);
                e.color = cpu_color;
                e.pcyc = cyc;
                wq.push_back(e);
                mcount++;
            end
            if (vga_valid) begin
                if (vq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_vga_valid: data %0h, required no valid", vga_data);
                end else begin
                    v = vq.pop_front();
                    chk("vga_data", vga_data, v.data);
                    checks++;
                    if ((cyc - v.rcyc) < v.lmin || (cyc - v.rcyc) > v.lmax) begin
                        errors++;
                        $display("FAIL vga_latency: got %0d cycles, required %0d..%0d", cyc - v.rcyc, v.lmin, v.lmax);
                    end
                    last_valid_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] v);
        ram[a] = v;
        ref_img[a] = v;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((wq.size() != 0 || vq.size() != 0) && t < 300) begin
            tick();
            t++;
        end
        if (t >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d writes %0d reads outstanding, required 0", wq.size(), vq.size());
        end
        repeat (3) tick();
    endtask

    task automatic vga_issue(input int a, input logic [31:0] d, input int lmin, input int lmax);
        vexp_t v;
        vga_req = 1'b1;
        vga_addr = AW'(a);
        v.data = d; v.rcyc = cyc; v.lmin = lmin; v.lmax = lmax;
        vq.push_back(v);
    endtask

    task automatic cpu_issue(input int word, input int nib, input logic [3:0] c);
        cpu_wr = 1'b1;
        cpu_pix_addr = PW'((word << 3) | nib);
        cpu_color = c;
    endtask

    initial begin
        int w0;
        int gap;
        int a;
        bit seen;
        for (int i = 0; i < 65536; i++) begin
            ram[i] = init_val(i);
            ref_img[i] = init_val(i);
        end
        rst = 1'b1;
        vga_req = 1'b0; vga_addr = '0;
        cpu_wr = 1'b0; cpu_pix_addr = '0; cpu_color = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vga_valid", 32'(vga_valid), 32'd0);
        chk("rst_vga_data", vga_data, 32'd0);
        chk("rst_overrun", 32'(vga_overrun), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) tick();

        // Idle VGA read: exactly three cycles
        preload(16'h0010, 32'h8765_4321);
        tick(); vga_issue(16'h0010, 32'h8765_4321, 3, 3);
        tick(); vga_req = 1'b0;
        drain();

        // Single pixel write
        preload(5, 32'hFFFF_FFFF);
        w0 = wr_count;
        tick(); cpu_pix_addr = PW'(43); cpu_color = 4'h2; cpu_wr = 1'b1;
        tick(); cpu_wr = 1'b0;
        drain();
        chk("pix_write_count", 32'(wr_count - w0), 32'd1);
        chk("pix_write_addr", last_addr, 32'd5);
        chk("pix_write_din", last_din, 32'hFFFF_2FFF);

        // Same-cycle contention: VGA first
        preload(16'h0020, 32'hCAFE_F00D);
        preload(0, 32'h0000_0000);
        tick(); cpu_issue(0, 0, 4'h1); vga_issue(16'h0020, 32'hCAFE_F00D, 3, 3);
        tick(); cpu_wr = 1'b0; vga_req = 1'b0;
        drain();
        chk("contention_order", 32'(last_wr_cyc > last_valid_cyc), 32'd1);
        chk("contention_din", last_din, 32'h0000_0001);

        // Overrun while CPU RMW in flight: only the newer address is read
        chk("overrun_before", 32'(vga_overrun), 32'd0);
        tick(); cpu_issue(16'h0060, 2, 4'h3);
        tick(); cpu_wr = 1'b0;
        tick(); vga_req = 1'b1; vga_addr = 16'h0030;
        tick(); vga_issue(16'h0031, ref_img[16'h0031], 3, 5);
        tick(); vga_req = 1'b0;
        drain();
        chk("overrun_after", 32'(vga_overrun), 32'd1);

        // Six back-to-back writes into a four-deep queue
        w0 = drop_count;
        for (int i = 0; i < 6; i++) begin
            tick(); cpu_issue(16'h0040 + i, i, 4'(i + 1));
        end
        tick(); cpu_wr = 1'b0;
        drain();
        chk("full_fifo_dropped", 32'(drop_count > w0), 32'd1);

        // Reset in the middle of a RAM write
        tick(); cpu_issue(16'h0050, 1, 4'h7);
        tick(); cpu_wr = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            if (ram_we) seen = 1'b1;
        end
        chk("reset_reached_write", 32'(seen), 32'd1);
        rst = 1'b0;
        #1;
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_vga_valid", 32'(vga_valid), 32'd0);
        chk("reset_overrun", 32'(vga_overrun), 32'd0);
        chk("reset_cpu_ready", 32'(cpu_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        w0 = wr_count;
        repeat (10) tick();
        chk("post_reset_no_write", 32'(wr_count - w0), 32'd0);
        chk("post_reset_ready", 32'(cpu_ready), 32'd1);
        chk("abandoned_word", ram[16'h0050], init_val(16'h0050));

        // Two writes to one word
        preload(2, 32'h0000_0000);
        w0 = wr_count;
        tick(); cpu_issue(2, 0, 4'hA);
        tick(); cpu_issue(2, 1, 4'hB);
        tick(); cpu_wr = 1'b0;
        drain();
`ifdef SCREEN_ARB_COALESCE_EN
        chk("coalesce_count", 32'(wr_count - w0), 32'd1);
`else
        chk("coalesce_count", 32'(wr_count - w0), 32'd2);
`endif
        chk("coalesce_din", last_din, 32'h0000_00BA);

        // Randomized traffic: CPU on words 0..15, VGA on a disjoint region
        gap = 10;
        for (int i = 0; i < 600; i++) begin
            tick();
            cpu_wr = ($urandom_range(0, 1) == 1);
            cpu_pix_addr = PW'(($urandom_range(0, 15) << 3) | $urandom_range(0, 7));
            cpu_color = 4'($urandom);
            vga_req = 1'b0;
            if (gap >= 6 && $urandom_range(0, 3) == 0) begin
                a = 256 + int'($urandom_range(0, 255));
                vga_issue(a, ref_img[a], 3, 5);
                gap = 0;
            end else begin
                gap++;
            end
        end
        tick(); cpu_wr = 1'b0; vga_req = 1'b0;
        drain();
        chk("final_wq_empty", 32'(wq.size()), 32'd0);
        chk("final_vq_empty", 32'(vq.size()), 32'd0);
        for (int i = 0; i < 512; i++) begin
            chk($sformatf("final_ram_%0h", i), ram[i], ref_img[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/screen_ram_arbiter.md
Name: screen_ram_arbiter

Overview:
- Owns the single port of the framebuffer RAM: 4-bit colour IDs, eight pixels per 32-bit word, nibble 0 in bits [3:0].
- Shares that port between two requesters:
  - the VGA scan path, which has strict priority and whole-word reads;
  - CPU pixel writes, which are buffered in a FIFO and applied as read-modify-write nibble updates.
- Sits between the display pipeline (which presents word addresses) and the screen RAM instance.

Parameters:
- ADDR_WIDTH, 16, RAM word address width.
- DATA_WIDTH, 32, RAM word width (fixed 8 x 4-bit pixels).
- PIX_ADDR_WIDTH, 19, CPU pixel index width (= ADDR_WIDTH+3).
- FIFO_DEPTH, 4, CPU write FIFO entries (power of 2).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- vga_req  in  1  one-cycle fetch request.
- vga_addr  in  ADDR_WIDTH  word address, sampled with vga_req.
- vga_data  out  DATA_WIDTH  fetched word, registered.
- vga_valid  out  1  one-cycle pulse, vga_data valid.
- vga_overrun  out  1  sticky: a pending VGA request was overwritten.
- cpu_wr  in  1  pixel write strobe.
- cpu_pix_addr  in  PIX_ADDR_WIDTH  pixel index; word = index>>3, nibble = index[2:0].
- cpu_color  in  4  colour ID.
- cpu_ready  out  1  FIFO not full.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DATA_WIDTH  RAM read data; synchronous, valid the cycle after the address.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM to IDLE, FIFO emptied, VGA pending flag cleared.
  - vga_data=0, vga_valid=0, vga_overrun=0, ram_we=0, ram_addr=0, ram_din=0, cpu_ready=1.
  - An in-flight RMW is abandoned; no write is issued.
- VGA capture:
  - vga_req sets pend and loads addr_q at the next edge.
  - If pend is already set and not being consumed that cycle, addr_q is overwritten (newest wins) and vga_overrun is set; it is cleared only by reset.
- CPU FIFO:
  - cpu_wr with cpu_ready=1 pushes {word, nibble, color}.
  - cpu_wr with cpu_ready=0 is ignored.
  - Push and pop in the same cycle leave the count unchanged.
  - cpu_ready = (count != FIFO_DEPTH).
  - Writes are applied in push order.
- FSM; ram_addr, ram_we and ram_din are combinational from state:
  - IDLE:
    - if pend: ram_addr=addr_q, go RD_VGA;
    - else if FIFO not empty: ram_addr=head word, go RD_CPU;
    - else stay.
    - VGA always wins a same-cycle tie.
  - RD_VGA:
    - vga_data<=ram_dout, vga_valid<=1 (high for exactly the next cycle).
    - pend cleared, unless vga_req is asserted this cycle, in which case the new request is kept.
    - Go IDLE.
  - RD_CPU: rmw<=ram_dout with the head nibble replaced by its colour; go WR_CPU.
  - WR_CPU: ram_we=1, ram_addr=head word, ram_din=rmw; pop the FIFO; go IDLE.
- ram_we is 0 in every state except WR_CPU.
- Latency:
  - vga_req in cycle k with FSM IDLE and no competing transaction gives vga_valid in cycle k+3.
  - Worst case is k+5, when RD_CPU was entered at k+1.
- Hazard: a VGA read of a word with queued CPU writes returns pre-write data. This is accepted; no forwarding.
- Word/nibble split is pure bit slicing; no arithmetic overflow paths.

Optional Feature:
- Macro: SCREEN_ARB_COALESCE_EN.
- Defined:
  - In RD_CPU, if a second FIFO entry exists and has the same word, its nibble is also merged into rmw.
  - Merge order is head first, second after; if both target the same nibble, the second entry's colour wins.
  - WR_CPU then pops 2 entries with one write.
- Undefined: exactly one entry per RMW.

Test Plan:
- Reset:
  - Assert rst low mid-WR_CPU.
  - Required: ram_we drops immediately, with no write; vga_valid=0, vga_overrun=0, cpu_ready=1.
  - Required: after release, FIFO empty, no RAM activity.
- Idle VGA read:
  - Preload RAM[0x0010]=0x87654321; vga_req with addr 0x0010 in cycle k.
  - Required: vga_valid high only in cycle k+3, vga_data=0x87654321.
- Pixel write:
  - RAM[5]=0xFFFFFFFF; cpu_wr with pix 43, color 0x2.
  - Required: exactly one ram_we cycle, ram_addr=5, ram_din=0xFFFF2FFF.
- Contention:
  - cpu_wr (pix 0, color 0x1) and vga_req (addr 0x20) in the same cycle.
  - Required: RAM read of 0x20 issued before RAM read of 0; vga_valid at k+3; the write completes afterwards.
- Overrun and full FIFO:
  - Two vga_req (0x30, then 0x31) while the FSM is in RD_CPU.
  - Required: vga_overrun=1; only 0x31 is read.
  - Six back-to-back cpu_wr to distinct words.
  - Required: cpu_ready low whenever count=4; dropped entries never reach RAM; final RAM matches the model.
- Coalesce (macro defined):
  - RAM[2]=0; writes pix 16 colour 0xA, then pix 17 colour 0xB.
  - Required: a single ram_we with ram_din=0x000000BA.
  - Macro undefined: two writes, the second with din 0x000000BA.
